fifo_bitplane_drain_ctrl: RTL and testbench

Read-side scheduler for the tier-2 bitplane FIFO bank (two groups of three 256x16 FIFOs: SP/MP/CP). It drains one group at a time in strict ping-pong order, reading the SP, MP and CP FIFOs of that group in sequence. Drained words go to the packet assembler through a valid/ready stream tagged with group and pass. When a group is fully consumed, the block returns it to the writer with a release pulse.

---
 rtl/fifo_bitplane_drain_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_fifo_bitplane_drain_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bitplane_drain_ctrl.sv
// fifo_bitplane_drain_ctrl
// Read-side scheduler for the two-group SP/MP/CP bitplane FIFO bank.
// Groups are drained strictly in ping-pong order (0,1,0,1,...). Within a
// group the SP, MP and CP FIFOs are read in that order. Every word goes
// through a 2-entry skid buffer onto a valid/ready stream tagged with its
// group and pass. A fully drained group is handed back with grp_free.
//
// Ports
//   rd_clk, rst_syn_n          clock, synchronous active-low reset
//   grp_ready[1:0]             writer finished filling group g (1-cycle pulse)
//   len_sp/len_mp/len_cp       word counts of the flagged group, taken with the pulse
//   empty_*_{0,1}              FIFO empty flags
//   dout_*_{0,1}               FIFO read data, valid the cycle after rd_en
//   rd_en_*_{0,1}              FIFO read enables, at most one high per cycle
//   out_data/valid/ready       drained word stream
//   out_group/out_pass/out_last tags of the head word (pass 1=SP, 2=MP, 3=CP)
//   grp_free[1:0]              group g released to the writer (1-cycle pulse)
//   busy                       scheduler not idle
//   err_ovf                    sticky: grp_ready for a group still pending/active
module fifo_bitplane_drain_ctrl #(
   parameter int LEN_W = 9
) (
   input  logic             rd_clk,
   input  logic             rst_syn_n,
   input  logic [1:0]       grp_ready,
   input  logic [LEN_W-1:0] len_sp,
   input  logic [LEN_W-1:0] len_mp,
   input  logic [LEN_W-1:0] len_cp,
   input  logic             empty_sp_0,
   input  logic             empty_mp_0,
   input  logic             empty_cp_0,
   input  logic             empty_sp_1,
   input  logic             empty_mp_1,
   input  logic             empty_cp_1,
   input  logic [15:0]      dout_sp_0,
   input  logic [15:0]      dout_mp_0,
   input  logic [15:0]      dout_cp_0,
   input  logic [15:0]      dout_sp_1,
   input  logic [15:0]      dout_mp_1,
   input  logic [15:0]      dout_cp_1,
   output logic             rd_en_sp_0,
   output logic             rd_en_mp_0,
   output logic             rd_en_cp_0,
   output logic             rd_en_sp_1,
   output logic             rd_en_mp_1,
   output logic             rd_en_cp_1,
   output logic [15:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_group,
   output logic [1:0]       out_pass,
   output logic             out_last,
   output logic [1:0]       grp_free,
   output logic             busy,
   output logic             err_ovf
);

   typedef enum logic [2:0] {S_IDLE, S_SP, S_MP, S_CP, S_DONE} state_t;

   typedef struct packed {
      logic       grp;
      logic [1:0] pass;
      logic       last;
   } tag_t;

   typedef struct packed {
      logic [15:0] data;
      logic        grp;
      logic [1:0]  pass;
      logic        last;
   } ent_t;

   // [group][pass index 0=SP,1=MP,2=CP]
   logic [1:0][2:0]             empty_v;
   logic [1:0][2:0][15:0]       dout_v;
   logic [1:0][2:0]             rd_vec;
   logic [1:0][2:0][LEN_W-1:0]  len_q;

   assign empty_v[0] = {empty_cp_0, empty_mp_0, empty_sp_0};
   assign empty_v[1] = {empty_cp_1, empty_mp_1, empty_sp_1};
   assign dout_v[0]  = {dout_cp_0, dout_mp_0, dout_sp_0};
   assign dout_v[1]  = {dout_cp_1, dout_mp_1, dout_sp_1};

   assign rd_en_sp_0 = rd_vec[0][0];
   assign rd_en_mp_0 = rd_vec[0][1];
   assign rd_en_cp_0 = rd_vec[0][2];
   assign rd_en_sp_1 = rd_vec[1][0];
   assign rd_en_mp_1 = rd_vec[1][1];
   assign rd_en_cp_1 = rd_vec[1][2];

   state_t           state;
   logic [1:0]       pending;
   logic             nxt_grp;
   logic             cur_grp;
   logic [LEN_W-1:0] rem;       // reads still to issue in the current pass
   logic             inflight;  // read issued last cycle, data on dout now
   tag_t             inf_tag;
   logic [1:0]       inf_idx;
   ent_t [1:0]       skid;      // [0] is the head
   logic [1:0]       occ;

   logic             in_pass;
   logic [1:0]       pass_idx;
   logic             pop;
   logic             room;
   logic             issue;
   ent_t             new_ent;

   always_comb begin
      in_pass  = 1'b0;
      pass_idx = 2'd0;
      case (state)
         S_SP: begin in_pass = 1'b1; pass_idx = 2'd0; end
         S_MP: begin in_pass = 1'b1; pass_idx = 2'd1; end
         S_CP: begin in_pass = 1'b1; pass_idx = 2'd2; end
         default: ;
      endcase
   end

   assign out_valid = (occ != 2'd0);
   assign out_data  = skid[0].data;
   assign out_group = skid[0].grp;
   assign out_pass  = skid[0].pass;
   assign out_last  = skid[0].last;

   assign pop = out_valid & out_ready;

   // The word in flight already owns a skid slot; a same-cycle pop frees one.
   assign room  = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
   assign issue = in_pass && (rem != '0) && !empty_v[cur_grp][pass_idx] && room;

   always_comb begin
      rd_vec = '0;
      if (issue) rd_vec[cur_grp][pass_idx] = 1'b1;
   end

   assign inf_idx = inf_tag.pass - 2'd1;
   assign new_ent = '{data: dout_v[inf_tag.grp][inf_idx],
                      grp:  inf_tag.grp,
                      pass: inf_tag.pass,
                      last: inf_tag.last};

   always_ff @(posedge rd_clk) begin
      if (!rst_syn_n) begin
         state    <= S_IDLE;
         pending  <= '0;
         nxt_grp  <= 1'b0;
         cur_grp  <= 1'b0;
         rem      <= '0;
         len_q    <= '0;
         inflight <= 1'b0;
         inf_tag  <= '0;
         skid     <= '0;
         occ      <= 2'd0;
         grp_free <= 2'b00;
         busy     <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         grp_free <= 2'b00;

         // A group is busy until the cycle after its release, so a pulse
         // coinciding with grp_free is still an overflow.
         for (int g = 0; g < 2; g++) begin
            if (grp_ready[g]) begin
               if (pending[g] || grp_free[g]) begin
                  err_ovf <= 1'b1;
               end else begin
                  pending[g] <= 1'b1;
                  len_q[g]   <= {len_cp, len_mp, len_sp};
               end
            end
         end

         inflight     <= issue;
         inf_tag.grp  <= cur_grp;
         inf_tag.pass <= pass_idx + 2'd1;
         inf_tag.last <= (rem == LEN_W'(1));

         case ({inflight, pop})
            2'b10: begin
               skid[occ[0]] <= new_ent;
               occ          <= occ + 2'd1;
            end
            2'b01: begin
               skid[0] <= skid[1];
               occ     <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd2) begin
                  skid[0] <= skid[1];
                  skid[1] <= new_ent;
               end else begin
                  skid[0] <= new_ent;
               end
            end
            default: ;
         endcase

         case (state)
            S_IDLE: begin
               if (pending[nxt_grp]) begin
                  cur_grp <= nxt_grp;
                  rem     <= len_q[nxt_grp][0];
                  state   <= S_SP;
                  busy    <= 1'b1;
               end
            end
            S_SP, S_MP, S_CP: begin
               if (issue) rem <= rem - 1'b1;
               // Leave on the cycle the final read issues so the next pass
               // starts without a bubble; an empty pass costs one cycle.
               if ((rem == '0) || (issue && (rem == LEN_W'(1)))) begin
                  case (state)
                     S_SP: begin
                        state <= S_MP;
                        rem   <= len_q[cur_grp][1];
                     end
                     S_MP: begin
                        state <= S_CP;
                        rem   <= len_q[cur_grp][2];
                     end
                     default: state <= S_DONE;
                  endcase
               end
            end
            S_DONE: begin
               if ((occ == 2'd0) && !inflight) begin
                  grp_free[cur_grp] <= 1'b1;
                  pending[cur_grp]  <= 1'b0;
                  nxt_grp           <= ~nxt_grp;
                  state             <= S_IDLE;
                  busy              <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_bitplane_drain_ctrl.sv
// Bench for fifo_bitplane_drain_ctrl: behavioural FIFO bank, word-level
// scoreboard keyed on ping-pong service order, per-cycle stream checks.
module tb_fifo_bitplane_drain_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  grp_ready;
   logic [8:0]  len_sp, len_mp, len_cp;
   logic [5:0]  empty_b = 6'h3f;
   logic [15:0] dout [6];
   logic        rd0, rd1, rd2, rd3, rd4, rd5;
   logic [5:0]  rd_v;
   logic [15:0] out_data;
   logic        out_valid, out_ready, out_group, out_last;
   logic [1:0]  out_pass, grp_free;
   logic        busy, err_ovf;

   assign rd_v = {rd5, rd4, rd3, rd2, rd1, rd0};

   fifo_bitplane_drain_ctrl #(.LEN_W(9)) dut (
      .rd_clk(clk), .rst_syn_n(rst_n), .grp_ready(grp_ready),
      .len_sp(len_sp), .len_mp(len_mp), .len_cp(len_cp),
      .empty_sp_0(empty_b[0]), .empty_mp_0(empty_b[1]), .empty_cp_0(empty_b[2]),
      .empty_sp_1(empty_b[3]), .empty_mp_1(empty_b[4]), .empty_cp_1(empty_b[5]),
      .dout_sp_0(dout[0]), .dout_mp_0(dout[1]), .dout_cp_0(dout[2]),
      .dout_sp_1(dout[3]), .dout_mp_1(dout[4]), .dout_cp_1(dout[5]),
      .rd_en_sp_0(rd0), .rd_en_mp_0(rd1), .rd_en_cp_0(rd2),
      .rd_en_sp_1(rd3), .rd_en_mp_1(rd4), .rd_en_cp_1(rd5),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_group(out_group), .out_pass(out_pass), .out_last(out_last),
      .grp_free(grp_free), .busy(busy), .err_ovf(err_ovf)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- FIFO bank model (index = group*3 + pass) ----------------
   logic [15:0] fq [6][$];
   logic [15:0] sh [6][$];   // shadow of everything written, consumed by the scoreboard
   bit   [5:0]  force_e = '0;
   bit   [5:0]  rd_snap = '0;

   initial for (int i = 0; i < 6; i++) dout[i] = '0;

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 6; i++) begin
         if (!rst_n) fq[i].delete();
         else if (rd_snap[i] && fq[i].size() > 0) dout[i] <= fq[i].pop_front();
         empty_b[i] <= (fq[i].size() == 0) || force_e[i];
      end
   end

   // ---------------- scoreboard / reference model ----------------
   bit mp [2];           // group handed over and not yet released
   int turn;             // group that must be served next
   bit exp_err;
   int job_rem [2][3];   // words of each pass still owed by the group
   int occ_b;            // words sitting in the block's buffer
   bit prev_rd;
   int first_rd = -1;
   int rd_cnt [6];
   int pop_cyc[$], pop_pass[$], pop_last[$], pop_grp[$];

   task automatic clear_logs();
      first_rd = -1;
      pop_cyc.delete(); pop_pass.delete(); pop_last.delete(); pop_grp.delete();
   endtask

   always @(negedge clk) begin
      bit pop;
      rd_snap = rd_v;
      if (!rst_n) begin
         mp[0] = 0; mp[1] = 0; turn = 0; exp_err = 0; occ_b = 0; prev_rd = 0;
         for (int g = 0; g < 2; g++) for (int p = 0; p < 3; p++) job_rem[g][p] = 0;
         for (int i = 0; i < 6; i++) sh[i].delete();
      end else begin
         pop = out_valid && out_ready;
         if (rd_v != 0) begin
            chk("rd_onehot", $countones(rd_v), 1);
            for (int i = 0; i < 6; i++) if (rd_v[i]) begin
               chk("rd_on_empty_flag", int'(empty_b[i]), 0);
               chk("rd_fifo_has_data", int'(fq[i].size() > 0), 1);
               rd_cnt[i]++;
            end
            chk("rd_room", int'(occ_b + int'(prev_rd) - int'(pop) < 2), 1);
            if (first_rd < 0) first_rd = cyc;
         end
         chk("out_valid", int'(out_valid), int'(occ_b != 0));
         if (pop) begin
            int p;
            p = 0;
            while (p < 3 && job_rem[turn][p] == 0) p++;
            if (!mp[turn] || p == 3) begin
               chk("unexpected_word", 1, 0);
            end else begin
               chk("word_data", int'(out_data),
                   sh[turn*3+p].size() > 0 ? int'(sh[turn*3+p].pop_front()) : -1);
               chk("word_group", int'(out_group), turn);
               chk("word_pass", int'(out_pass), p + 1);
               chk("word_last", int'(out_last), int'(job_rem[turn][p] == 1));
               job_rem[turn][p]--;
            end
            pop_cyc.push_back(cyc); pop_pass.push_back(int'(out_pass));
            pop_last.push_back(int'(out_last)); pop_grp.push_back(int'(out_group));
         end
         chk("err_ovf", int'(err_ovf), int'(exp_err));
         for (int g = 0; g < 2; g++) if (grp_ready[g]) begin
            if (mp[g]) exp_err = 1;
            else begin
               mp[g] = 1;
               job_rem[g][0] = int'(len_sp);
               job_rem[g][1] = int'(len_mp);
               job_rem[g][2] = int'(len_cp);
            end
         end
         for (int g = 0; g < 2; g++) if (grp_free[g]) begin
            chk("free_order", g, turn);
            chk("free_was_pending", int'(mp[g]), 1);
            chk("free_drained", job_rem[g][0] + job_rem[g][1] + job_rem[g][2], 0);
            mp[g] = 0;
            turn  = 1 - g;
         end
         occ_b   = occ_b + int'(prev_rd) - int'(pop);
         prev_rd = (rd_v != 0);
      end
   end

   // ---------------- stimulus ----------------
   int ord_mode = 0;
   int gr_cyc;

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ord_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         logic [15:0] d;
         d = 16'($urandom_range(0, 65535));
         fq[i].push_back(d);
         sh[i].push_back(d);
      end
   endtask

   task automatic prefill(input int g, input int a, input int b, input int c);
      push(g*3, a); push(g*3+1, b); push(g*3+2, c);
      tick();
   endtask

   task automatic send(input int g, input int a, input int b, input int c);
      len_sp = 9'(a); len_mp = 9'(b); len_cp = 9'(c);
      grp_ready = 2'b00;
      grp_ready[g] = 1'b1;
      gr_cyc = cyc;
      tick();
      grp_ready = 2'b00;
   endtask

   task automatic wait_free(input int g, input int budget);
      int n;
      n = 0;
      while (mp[g] && n < budget) begin tick(); n++; end
      chk("wait_free_timeout", int'(mp[g]), 0);
   endtask

   function automatic int cnt_pass(input int p);
      int c;
      c = 0;
      foreach (pop_pass[i]) if (pop_pass[i] == p) c++;
      return c;
   endfunction

   task automatic wait_pass(input int p, input int n, input int budget);
      int k;
      k = 0;
      while (cnt_pass(p) < n && k < budget) begin tick(); k++; end
      chk("wait_pass_timeout", int'(cnt_pass(p) >= n), 1);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_rd"}, int'(rd_v), 0);
      chk({nm, "_valid"}, int'(out_valid), 0);
      chk({nm, "_data"}, int'(out_data), 0);
      chk({nm, "_group"}, int'(out_group), 0);
      chk({nm, "_pass"}, int'(out_pass), 0);
      chk({nm, "_last"}, int'(out_last), 0);
      chk({nm, "_free"}, int'(grp_free), 0);
      chk({nm, "_busy"}, int'(busy), 0);
      chk({nm, "_err"}, int'(err_ovf), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_pass [9];
      int s;
      exp_pass = '{1, 1, 1, 2, 2, 3, 3, 3, 3};
      rst_n = 1'b0; grp_ready = 2'b00; len_sp = '0; len_mp = '0; len_cp = '0;
      repeat (3) tick();
      chk_reset_outs("reset");
      rst_n = 1'b1;
      tick();

      // T1: group 0, 3/2/4, prefilled, full-rate consumer
      prefill(0, 3, 2, 4);
      clear_logs();
      send(0, 3, 2, 4);
      tick();
      chk("t1_busy", int'(busy), 1);
      wait_free(0, 200);
      tick();
      chk("t1_idle", int'(busy), 0);
      chk("t1_rd_latency", first_rd - gr_cyc, 2);
      chk("t1_words", pop_pass.size(), 9);
      if (pop_pass.size() == 9) begin
         for (int i = 0; i < 9; i++) chk("t1_pass_seq", pop_pass[i], exp_pass[i]);
         chk("t1_no_gap", pop_cyc[8] - pop_cyc[0], 8);
         chk("t1_last3", pop_last[2], 1);
         chk("t1_last5", pop_last[4], 1);
         chk("t1_last9", pop_last[8], 1);
         chk("t1_last_cnt", pop_last.sum(), 3);
      end

      // T2: group 1 arrives first but group 0 is owed service after reset
      do_reset();
      prefill(1, 2, 3, 1);
      prefill(0, 2, 2, 2);
      clear_logs();
      send(1, 2, 3, 1);
      repeat (20) tick();
      chk("t2_no_early_read", first_rd, -1);
      send(0, 2, 2, 2);
      wait_free(1, 300);
      chk("t2_words", pop_grp.size(), 12);
      if (pop_grp.size() == 12) begin
         chk("t2_first_grp", pop_grp[0], 0);
         chk("t2_grp0_end", pop_grp[5], 0);
         chk("t2_grp1_start", pop_grp[6], 1);
      end

      // T3: group 0, 0/0/5 -- two one-cycle empty passes
      prefill(0, 0, 0, 5);
      clear_logs();
      send(0, 0, 0, 5);
      wait_free(0, 200);
      chk("t3_rd_latency", first_rd - gr_cyc, 4);
      chk("t3_cp_words", cnt_pass(3), 5);
      chk("t3_words", pop_pass.size(), 5);

      // T4: group 1, 256/0/0, consumer pattern 1,0,0,1
      prefill(1, 256, 0, 0);
      clear_logs();
      ord_mode = 1;
      send(1, 256, 0, 0);
      wait_free(1, 3000);
      ord_mode = 0;
      chk("t4_words", pop_pass.size(), 256);

      // T5: group 0, MP FIFO reports empty for 10 cycles mid-pass
      prefill(0, 4, 12, 4);
      clear_logs();
      ord_mode = 2;
      send(0, 4, 12, 4);
      wait_pass(2, 3, 200);
      force_e[1] = 1'b1;
      tick();
      s = rd_cnt[1];
      repeat (10) tick();
      chk("t5_mp_reads_while_empty", rd_cnt[1] - s, 0);
      force_e[1] = 1'b0;
      wait_free(0, 400);
      ord_mode = 0;
      chk("t5_words", pop_pass.size(), 20);

      // T6: reset during CP of group 1, then clean restart of group 0
      prefill(1, 2, 2, 20);
      clear_logs();
      send(1, 2, 2, 20);
      wait_pass(3, 3, 200);
      rst_n = 1'b0;
      tick();
      chk_reset_outs("midreset");
      rst_n = 1'b1;
      tick();
      prefill(0, 3, 3, 3);
      clear_logs();
      send(0, 3, 3, 3);
      wait_free(0, 200);
      chk("t6_restart_words", pop_pass.size(), 9);

      // Overflow: group 0 handed over twice while still pending
      send(0, 2, 0, 0);
      tick();
      chk("ovf_clear_before", int'(err_ovf), 0);
      send(0, 2, 0, 0);
      chk("ovf_set", int'(err_ovf), 1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
